regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with 2-slot M-result buffer and LL flag
module regfile_wb_arbiter (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        PWrite,
   input  logic [4:0]  PReg,
   input  logic [31:0] PData,
   input  logic        MValid,
   input  logic [4:0]  MReg,
   input  logic [31:0] MData,
   output logic        MReady,
   input  logic [4:0]  Read1,
   input  logic [4:0]  Read2,
   output logic        Stall1,
   output logic        Stall2,
   output logic        RegWrite,
   output logic [4:0]  WriteReg,
   output logic [31:0] WriteData,
   input  logic        LLSet,
   input  logic        LLClear,
   output logic        LLbit,
   output logic [1:0]  Count
);

   logic [4:0]  reg_q  [2];
   logic [4:0]  reg_d  [2];
   logic [31:0] data_q [2];
   logic [31:0] data_d [2];
   logic [1:0]  v_q, v_d;
   logic        head_q, head_d;
   logic        tail_q, tail_d;
   logic [1:0]  count_q, count_d;
   logic        llbit_q, llbit_d;

   logic        p_active, head_occ, head_v, pop, enq;
   logic [1:0]  hit1, hit2;

   always_comb begin
      p_active = ~Reset & PWrite & (PReg != 5'd0);
      MReady   = ~Reset & (count_q != 2'd2);
      head_occ = (count_q != 2'd0);
      head_v   = v_q[head_q];
      // An invalidated head drains even while P owns the port; a valid one waits.
      pop      = ~Reset & head_occ & (~head_v | ~p_active);
      enq      = MValid & MReady & (MReg != 5'd0) & ~(p_active & (PReg == MReg));

      RegWrite  = 1'b0;
      WriteReg  = 5'd0;
      WriteData = 32'd0;
      if (p_active) begin
         RegWrite  = 1'b1;
         WriteReg  = PReg;
         WriteData = PData;
      end else if (~Reset & head_occ & head_v) begin
         RegWrite  = 1'b1;
         WriteReg  = reg_q[head_q];
         WriteData = data_q[head_q];
      end

      for (int i = 0; i < 2; i++) begin
         hit1[i] = v_q[i] & (reg_q[i] == Read1);
         hit2[i] = v_q[i] & (reg_q[i] == Read2);
      end
      Stall1 = ~Reset & (Read1 != 5'd0) & (|hit1);
      Stall2 = ~Reset & (Read2 != 5'd0) & (|hit2);

      reg_d   = reg_q;
      data_d  = data_q;
      v_d     = v_q;
      head_d  = head_q;
      tail_d  = tail_q;
      for (int i = 0; i < 2; i++) begin
         if (p_active && (reg_q[i] == PReg)) v_d[i] = 1'b0;
      end
      if (pop) begin
         v_d[head_q] = 1'b0;
         head_d      = ~head_q;
      end
      if (enq) begin
         reg_d[tail_q]  = MReg;
         data_d[tail_q] = MData;
         v_d[tail_q]    = 1'b1;
         tail_d         = ~tail_q;
      end
      count_d = count_q + {1'b0, enq} - {1'b0, pop};

      llbit_d = llbit_q;
      if (LLClear)    llbit_d = 1'b0;
      else if (LLSet) llbit_d = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         v_q     <= 2'b00;
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= 2'd0;
         llbit_q <= 1'b0;
      end else begin
         v_q     <= v_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         llbit_q <= llbit_d;
      end
      reg_q  <= reg_d;
      data_q <= data_d;
   end

   assign LLbit = llbit_q;
   assign Count = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        PWrite;
   logic [4:0]  PReg;
   logic [31:0] PData;
   logic        MValid;
   logic [4:0]  MReg;
   logic [31:0] MData;
   logic        MReady;
   logic [4:0]  Read1, Read2;
   logic        Stall1, Stall2;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        LLSet, LLClear, LLbit;
   logic [1:0]  Count;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_wb_arbiter dut (
      .Clk(Clk), .Reset(Reset),
      .PWrite(PWrite), .PReg(PReg), .PData(PData),
      .MValid(MValid), .MReg(MReg), .MData(MData), .MReady(MReady),
      .Read1(Read1), .Read2(Read2), .Stall1(Stall1), .Stall2(Stall2),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .LLSet(LLSet), .LLClear(LLClear), .LLbit(LLbit), .Count(Count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
      check({tag, ".we"},   32'(RegWrite),  32'(we));
      check({tag, ".reg"},  32'(WriteReg),  32'(r));
      check({tag, ".data"}, WriteData,      d);
   endtask

   initial begin
      Reset = 1'b1; PWrite = 0; PReg = 0; PData = 0;
      MValid = 0; MReg = 0; MData = 0; Read1 = 0; Read2 = 0;
      LLSet = 0; LLClear = 0;
      tick();
      // reset in effect: outputs forced idle, requests dropped
      PWrite = 1; PReg = 5'd2; PData = 32'h1234; MValid = 1; MReg = 5'd6;
      settle();
      wr("rst", 0, 0, 0);
      check("rst.mready", 32'(MReady), 0);
      tick();
      Reset = 0; PWrite = 0; MValid = 0;
      settle();
      check("rst.count", 32'(Count), 0);
      check("rst.mready_after", 32'(MReady), 1);
      check("rst.llbit", 32'(LLbit), 0);
      wr("rst.idle", 0, 0, 0);

      // single M result, 1-cycle latency, stall while pending
      MValid = 1; MReg = 5'd5; MData = 32'hDEADBEEF; Read1 = 5'd5; Read2 = 5'd6;
      settle();
      check("m1.stall_pre", 32'(Stall1), 0);
      tick();
      MValid = 0;
      settle();
      check("m1.count", 32'(Count), 1);
      wr("m1.drain", 1, 5, 32'hDEADBEEF);
      check("m1.stall1", 32'(Stall1), 1);
      check("m1.stall2", 32'(Stall2), 0);
      tick();
      check("m1.count_after", 32'(Count), 0);
      check("m1.stall1_after", 32'(Stall1), 0);
      wr("m1.idle", 0, 0, 0);

      // P starves M; buffer fills and backpressures
      PWrite = 1; PReg = 5'd3; PData = 32'h33;
      MValid = 1; MReg = 5'd7; MData = 32'h70;
      settle();
      wr("p4.c1", 1, 3, 32'h33);
      tick();
      MReg = 5'd8; MData = 32'h80;
      settle();
      check("p4.c2.count", 32'(Count), 1);
      check("p4.c2.mready", 32'(MReady), 1);
      tick();
      MReg = 5'd9; MData = 32'h90;
      settle();
      check("p4.c3.count", 32'(Count), 2);
      check("p4.c3.mready", 32'(MReady), 0);
      wr("p4.c3", 1, 3, 32'h33);
      tick();
      check("p4.c4.count", 32'(Count), 2);
      tick();
      PWrite = 0;
      settle();
      wr("p4.w7", 1, 7, 32'h70);
      check("p4.w7.mready", 32'(MReady), 0);
      tick();
      check("p4.w8.count", 32'(Count), 1);
      check("p4.w8.mready", 32'(MReady), 1);
      wr("p4.w8", 1, 8, 32'h80);
      tick();
      MValid = 0;
      settle();
      check("p4.w9.count", 32'(Count), 1);
      wr("p4.w9", 1, 9, 32'h90);
      tick();
      check("p4.end.count", 32'(Count), 0);

      // newer P write invalidates buffered reg 10
      MValid = 1; MReg = 5'd10; MData = 32'h1; Read1 = 5'd10;
      tick();
      MValid = 0; PWrite = 1; PReg = 5'd10; PData = 32'h2;
      settle();
      wr("inv.p", 1, 10, 32'h2);
      check("inv.stall", 32'(Stall1), 1);
      tick();
      PWrite = 0;
      settle();
      check("inv.count", 32'(Count), 1);
      wr("inv.nowrite", 0, 0, 0);
      check("inv.stall_after", 32'(Stall1), 0);
      tick();
      check("inv.drained", 32'(Count), 0);

      // same-cycle collision: P wins, M discarded
      MValid = 1; MReg = 5'd4; MData = 32'h44; PWrite = 1; PReg = 5'd4; PData = 32'h55;
      settle();
      wr("col", 1, 4, 32'h55);
      tick();
      MValid = 0; PWrite = 0;
      settle();
      check("col.count", 32'(Count), 0);
      wr("col.after", 0, 0, 0);
      MValid = 1; MReg = 5'd0; MData = 32'h99;
      settle();
      check("m0.mready", 32'(MReady), 1);
      tick();
      MValid = 0;
      settle();
      check("m0.count", 32'(Count), 0);
      wr("m0", 0, 0, 0);
      PWrite = 1; PReg = 5'd0; PData = 32'h77;
      settle();
      wr("p0", 0, 0, 0);
      PWrite = 0;

      // invalid head drains while P stays active on another register
      MValid = 1; MReg = 5'd11; MData = 32'hB1;
      tick();
      PWrite = 1; PReg = 5'd11; PData = 32'hB2; MReg = 5'd12; MData = 32'hC1;
      tick();
      MValid = 0; PReg = 5'd20; PData = 32'h20;
      settle();
      check("vh.count2", 32'(Count), 2);
      wr("vh.p", 1, 20, 32'h20);
      tick();
      PWrite = 0;
      settle();
      check("vh.count1", 32'(Count), 1);
      wr("vh.w12", 1, 12, 32'hC1);
      tick();
      check("vh.empty", 32'(Count), 0);

      // LL flag
      LLSet = 1;
      tick();
      check("ll.set", 32'(LLbit), 1);
      LLClear = 1;
      tick();
      check("ll.both", 32'(LLbit), 0);
      LLClear = 0;
      tick();
      LLSet = 0;
      check("ll.reset_pre", 32'(LLbit), 1);

      // reset with a full buffer discards everything
      PWrite = 1; PReg = 5'd1; PData = 32'h1;
      MValid = 1; MReg = 5'd13; MData = 32'hD;
      tick();
      MReg = 5'd14; MData = 32'hE;
      tick();
      MValid = 0; PWrite = 0; Read1 = 5'd13;
      settle();
      check("rst2.count_pre", 32'(Count), 2);
      Reset = 1;
      settle();
      wr("rst2.during", 0, 0, 0);
      check("rst2.stall", 32'(Stall1), 0);
      tick();
      Reset = 0;
      settle();
      check("rst2.count", 32'(Count), 0);
      check("rst2.llbit", 32'(LLbit), 0);
      check("rst2.mready", 32'(MReady), 1);
      wr("rst2.nodrain", 0, 0, 0);
      tick();
      wr("rst2.nodrain2", 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
